bus_arbiter: RTL and testbench

Shares the core's single memory bus port among three masters: debug (m2), load/store from EX (m0) and instruction fetch from IF (m1). It runs a single-outstanding request/grant/response FSM toward the slave and raises a pipeline hold flag to `ctrl` while a core-side master is waiting. A starvation guard keeps fetch from being locked out by back-to-back loads and stores.

---
 rtl/bus_arbiter_pkg.sv | 36 +++
 rtl/bus_arbiter_arb_prio.sv | 26 ++
 rtl/bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
// Shared types for the memory bus arbiter: FSM state and bus owner encodings,
// the starvation counter width, and a helper that maps a one-hot grant onto
// an owner code.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbReq  = 2'd1,
        ArbResp = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        ArbM0   = 2'd0,
        ArbM1   = 2'd1,
        ArbM2   = 2'd2,
        ArbNone = 2'd3
    } arb_owner_e;

    localparam int STARVE_W = 8;

    // Bit 0 = m0 (load/store), bit 1 = m1 (fetch), bit 2 = m2 (debug)
    function automatic arb_owner_e owner_from_onehot(input logic [2:0] gnt);
        arb_owner_e owner;
        owner = ArbNone;
        if (gnt[2]) begin
            owner = ArbM2;
        end else if (gnt[1]) begin
            owner = ArbM1;
        end else if (gnt[0]) begin
            owner = ArbM0;
        end
        return owner;
    endfunction

endpackage

// File: rtl/bus_arbiter_arb_prio.sv
// arb_prio
// Combinational fixed-priority picker with a starvation override.
// Ports:
//   req_i        [2:0] request bits (0 = m0, 1 = m1, 2 = m2)
//   starve_ovr_i       promotes m1 above m0 (m2 still wins)
//   gnt_o        [2:0] one-hot grant, all zero when nobody requests
module arb_prio (
    input  logic [2:0] req_i,
    input  logic       starve_ovr_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        gnt_o = 3'b000;
        if (req_i[2]) begin
            gnt_o = 3'b100;
        end else if (starve_ovr_i && req_i[1]) begin
            gnt_o = 3'b010;
        end else if (req_i[0]) begin
            gnt_o = 3'b001;
        end else if (req_i[1]) begin
            gnt_o = 3'b010;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares one memory bus port among load/store (m0), instruction fetch (m1)
// and debug (m2) with a single-outstanding request/grant/response FSM.
// Ports:
//   clk, rstn            clock; asynchronous active-high reset (rstn = 1 resets)
//   mN_req/we/addr/wdata master request and payload
//   mN_gnt_o, mN_rvalid_o one-cycle accept / completion pulses
//   mN_rdata_o           read data, non-zero only with mN_rvalid_o
//   s_req/we/addr/wdata  registered request toward the slave
//   s_gnt_i, s_rvalid_i, s_rdata_i  slave handshake and read data
//   hold_flag_o          pipeline hold while m0 or m1 is still waiting
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    input  logic              m2_req_i,
    input  logic              m2_we_i,
    input  logic [ADDR_W-1:0] m2_addr_i,
    input  logic [DATA_W-1:0] m2_wdata_i,
    output logic              m2_gnt_o,
    output logic              m2_rvalid_o,
    output logic [DATA_W-1:0] m2_rdata_o,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic              s_gnt_i,
    input  logic              s_rvalid_i,
    input  logic [DATA_W-1:0] s_rdata_i,
    output logic              hold_flag_o
);

    localparam logic [STARVE_W-1:0] StarveMaxC = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q;
    arb_owner_e          owner_q;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                s_req_q;
    logic                s_we_q;
    logic [ADDR_W-1:0]   s_addr_q;
    logic [DATA_W-1:0]   s_wdata_q;

    logic [2:0] req_vec;
    logic [2:0] pick;
    logic       starve_ovr;
    logic [2:0] owner_hit;
    logic       txn_done;
    logic [2:0] gnt_vec;
    logic [2:0] rvalid_vec;

    assign req_vec    = {m2_req_i, m1_req_i, m0_req_i};
    assign starve_ovr = (starve_q == StarveMaxC) && m1_req_i;

    arb_prio u_prio (
        .req_i        (req_vec),
        .starve_ovr_i (starve_ovr),
        .gnt_o        (pick)
    );

    // Fetch loses an arbitration whenever it is requesting in IDLE but the
    // picker chose someone else; the count only matters while m1 waits.
    always_comb begin
        starve_d = starve_q;
        if (!m1_req_i) begin
            starve_d = '0;
        end else if (state_q == ArbIdle) begin
            if (pick[1]) begin
                starve_d = '0;
            end else if (starve_q != StarveMaxC) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // FSM, owner and slave-side payload latches. The payload is captured
    // once at the IDLE pick, so master-side changes afterwards are not seen.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= ArbIdle;
            owner_q   <= ArbNone;
            starve_q  <= '0;
            s_req_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                ArbIdle: begin
                    if (|req_vec) begin
                        owner_q <= owner_from_onehot(pick);
                        s_req_q <= 1'b1;
                        state_q <= ArbReq;
                        if (pick[2]) begin
                            s_we_q    <= m2_we_i;
                            s_addr_q  <= m2_addr_i;
                            s_wdata_q <= m2_wdata_i;
                        end else if (pick[1]) begin
                            s_we_q    <= m1_we_i;
                            s_addr_q  <= m1_addr_i;
                            s_wdata_q <= m1_wdata_i;
                        end else begin
                            s_we_q    <= m0_we_i;
                            s_addr_q  <= m0_addr_i;
                            s_wdata_q <= m0_wdata_i;
                        end
                    end
                end
                ArbReq: begin
                    if (s_gnt_i) begin
                        s_req_q <= 1'b0;
                        if (s_rvalid_i) begin
                            owner_q <= ArbNone;
                            state_q <= ArbIdle;
                        end else begin
                            state_q <= ArbResp;
                        end
                    end
                end
                ArbResp: begin
                    if (s_rvalid_i) begin
                        owner_q <= ArbNone;
                        state_q <= ArbIdle;
                    end
                end
                default: begin
                    owner_q <= ArbNone;
                    s_req_q <= 1'b0;
                    state_q <= ArbIdle;
                end
            endcase
        end
    end

    // Grant and completion pulses follow the slave inputs in the same cycle
    assign owner_hit  = {owner_q == ArbM2, owner_q == ArbM1, owner_q == ArbM0};
    assign txn_done   = ((state_q == ArbReq) && s_gnt_i && s_rvalid_i) ||
                        ((state_q == ArbResp) && s_rvalid_i);
    assign gnt_vec    = ((state_q == ArbReq) && s_gnt_i) ? owner_hit : 3'b000;
    assign rvalid_vec = txn_done ? owner_hit : 3'b000;

    assign m0_gnt_o    = gnt_vec[0];
    assign m1_gnt_o    = gnt_vec[1];
    assign m2_gnt_o    = gnt_vec[2];
    assign m0_rvalid_o = rvalid_vec[0];
    assign m1_rvalid_o = rvalid_vec[1];
    assign m2_rvalid_o = rvalid_vec[2];
    assign m0_rdata_o  = rvalid_vec[0] ? s_rdata_i : '0;
    assign m1_rdata_o  = rvalid_vec[1] ? s_rdata_i : '0;
    assign m2_rdata_o  = rvalid_vec[2] ? s_rdata_i : '0;

    assign s_req_o   = s_req_q;
    assign s_we_o    = s_we_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;

    // Debug traffic never stalls the pipeline
    assign hold_flag_o = (m0_req_i & ~m0_rvalid_o) | (m1_req_i & ~m1_rvalid_o);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Directed bench for bus_arbiter: reset values, write payload latching,
// m0/m1 ordering, starvation promotion, debug priority, combined gnt/rvalid
// and reset during a response.
module tb_bus_arbiter;

    logic        clk;
    logic        rstn;
    logic        m0_req, m0_we, m1_req, m1_we, m2_req, m2_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m2_addr, m2_wdata;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o, m2_gnt_o, m2_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o, m2_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic        s_gnt_i, s_rvalid_i;
    logic [31:0] s_rdata_i;
    logic        hold_flag_o;

    int checks   = 0;
    int failures = 0;

    logic [2:0]  g, rv;
    logic        holdG, holdRv, leak;
    logic [31:0] rd;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .m2_req_i(m2_req), .m2_we_i(m2_we), .m2_addr_i(m2_addr), .m2_wdata_i(m2_wdata),
        .m2_gnt_o(m2_gnt_o), .m2_rvalid_o(m2_rvalid_o), .m2_rdata_o(m2_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .hold_flag_o(hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_req"}, {31'd0, s_req_o}, 32'd0);
        checkOutput({tag, "_s_we"}, {31'd0, s_we_o}, 32'd0);
        checkOutput({tag, "_s_addr"}, s_addr_o, 32'd0);
        checkOutput({tag, "_s_wdata"}, s_wdata_o, 32'd0);
        checkOutput({tag, "_gnts"}, {29'd0, m2_gnt_o, m1_gnt_o, m0_gnt_o}, 32'd0);
        checkOutput({tag, "_rvalids"}, {29'd0, m2_rvalid_o, m1_rvalid_o, m0_rvalid_o}, 32'd0);
        checkOutput({tag, "_rdata"}, m0_rdata_o | m1_rdata_o | m2_rdata_o, 32'd0);
        checkOutput({tag, "_hold"}, {31'd0, hold_flag_o}, 32'd0);
    endtask

    // Drives the slave side for one transaction starting from an IDLE cycle
    // with requests already set. Completed masters drop their request in the
    // following IDLE cycle unless keep is set.
    task automatic applyStimulus(input bit together, input bit keep, input logic [31:0] rdata,
                                 output logic [2:0] gOut, output logic [2:0] rvOut,
                                 output logic hG, output logic hRv,
                                 output logic [31:0] rdOut, output logic leakOut);
        logic [2:0] drop;
        @(posedge clk);
        @(negedge clk);
        checkOutput("s_req_in_req", {31'd0, s_req_o}, 32'd1);
        s_gnt_i    = 1'b1;
        s_rvalid_i = together;
        s_rdata_i  = rdata;
        #1;
        gOut = {m2_gnt_o, m1_gnt_o, m0_gnt_o};
        hG   = hold_flag_o;
        if (!together) begin
            @(negedge clk);
            s_gnt_i    = 1'b0;
            s_rvalid_i = 1'b1;
            #1;
        end
        rvOut   = {m2_rvalid_o, m1_rvalid_o, m0_rvalid_o};
        hRv     = hold_flag_o;
        rdOut   = m0_rdata_o | m1_rdata_o | m2_rdata_o;
        leakOut = (!rvOut[0] && m0_rdata_o != 0) || (!rvOut[1] && m1_rdata_o != 0) ||
                  (!rvOut[2] && m2_rdata_o != 0);
        @(negedge clk);
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        drop = keep ? 3'b000 : rvOut;
        if (drop[0]) m0_req = 1'b0;
        if (drop[1]) m1_req = 1'b0;
        if (drop[2]) m2_req = 1'b0;
    endtask

    initial begin
        rstn = 1'b1;
        {m0_req, m0_we, m1_req, m1_we, m2_req, m2_we} = '0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata, m2_addr, m2_wdata} = '0;
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        rstn = 1'b0;

        // Write from m0: payload latched at REQ entry and held until gnt
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        checkOutput("wr_s_req", {31'd0, s_req_o}, 32'd1);
        checkOutput("wr_s_we", {31'd0, s_we_o}, 32'd1);
        checkOutput("wr_s_addr", s_addr_o, 32'h100);
        checkOutput("wr_s_wdata", s_wdata_o, 32'h55);
        checkOutput("wr_no_gnt_yet", {31'd0, m0_gnt_o}, 32'd0);
        checkOutput("wr_hold", {31'd0, hold_flag_o}, 32'd1);
        @(negedge clk);
        checkOutput("wr_addr_stable", s_addr_o, 32'h100);
        checkOutput("wr_wdata_stable", s_wdata_o, 32'h55);
        s_gnt_i = 1'b1;
        #1;
        checkOutput("wr_gnt", {31'd0, m0_gnt_o}, 32'd1);
        checkOutput("wr_no_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
        @(negedge clk);
        s_gnt_i = 1'b0;
        checkOutput("wr_resp_s_req_low", {31'd0, s_req_o}, 32'd0);
        s_rvalid_i = 1'b1;
        #1;
        checkOutput("wr_rvalid", {31'd0, m0_rvalid_o}, 32'd1);
        checkOutput("wr_hold_clear", {31'd0, hold_flag_o}, 32'd0);
        @(negedge clk);
        s_rvalid_i = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0;

        // m0 and m1 together: m0 first, then m1; hold until m1 completes
        m0_addr = 32'h200; m1_addr = 32'h300;
        m0_req = 1'b1; m1_req = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h1111, g, rv, holdG, holdRv, rd, leak);
        checkOutput("pair_first_gnt", {29'd0, g}, 32'd1);
        checkOutput("pair_first_rvalid", {29'd0, rv}, 32'd1);
        checkOutput("pair_first_rdata", rd, 32'h1111);
        checkOutput("pair_hold_at_m0_done", {31'd0, holdRv}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h2222, g, rv, holdG, holdRv, rd, leak);
        checkOutput("pair_second_gnt", {29'd0, g}, 32'd2);
        checkOutput("pair_hold_at_m1_gnt", {31'd0, holdG}, 32'd1);
        checkOutput("pair_second_rvalid", {29'd0, rv}, 32'd2);
        checkOutput("pair_second_rdata", rd, 32'h2222);
        checkOutput("pair_hold_at_m1_done", {31'd0, holdRv}, 32'd0);

        // Starvation: m1 loses 8 times, wins the 9th, then counter restarts
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0, g, rv, holdG, holdRv, rd, leak);
            checkOutput($sformatf("starve_m0_win_%0d", i), {29'd0, g}, 32'd1);
        end
        applyStimulus(1'b1, 1'b1, 32'h0, g, rv, holdG, holdRv, rd, leak);
        checkOutput("starve_m1_promoted", {29'd0, g}, 32'd2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0, g, rv, holdG, holdRv, rd, leak);
            checkOutput($sformatf("starve_restart_m0_%0d", i), {29'd0, g}, 32'd1);
        end

        // Counter saturated: debug still wins, then fetch is promoted
        m2_req = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0, g, rv, holdG, holdRv, rd, leak);
        checkOutput("dbg_beats_starved", {29'd0, g}, 32'd4);
        checkOutput("dbg_hold_with_m0m1", {31'd0, holdG}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, g, rv, holdG, holdRv, rd, leak);
        checkOutput("sat_m1_after_dbg", {29'd0, g}, 32'd2);
        m0_req = 1'b0;
        m2_req = 1'b1;
        #1;
        checkOutput("dbg_alone_hold", {31'd0, hold_flag_o}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, g, rv, holdG, holdRv, rd, leak);
        checkOutput("dbg_alone_gnt", {29'd0, g}, 32'd4);
        checkOutput("dbg_alone_hold_gnt", {31'd0, holdG}, 32'd0);

        // gnt and rvalid in the same cycle
        m0_req = 1'b1; m0_addr = 32'h400;
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, g, rv, holdG, holdRv, rd, leak);
        checkOutput("same_cycle_gnt", {29'd0, g}, 32'd1);
        checkOutput("same_cycle_rvalid", {29'd0, rv}, 32'd1);
        checkOutput("same_cycle_rdata", rd, 32'hDEADBEEF);
        checkOutput("same_cycle_no_leak", {31'd0, leak}, 32'd0);

        // Reset while in RESP, then a late rvalid must be ignored
        m0_req = 1'b1; m0_addr = 32'h500; m0_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_gnt_i = 1'b1;
        @(negedge clk);
        s_gnt_i = 1'b0;
        rstn = 1'b1;
        m0_req = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        rstn = 1'b0;
        s_rvalid_i = 1'b1;
        s_rdata_i = 32'hCAFE;
        #1;
        checkAllZero("late_rvalid");
        @(negedge clk);
        s_rvalid_i = 1'b0;
        s_rdata_i = '0;
        #1;
        checkAllZero("after_reset_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
